// File: rtl/bram_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_pipe_pkg
// Function : Shared sizing helpers and legal-range predicates for bram_pipe_ctrl
// Revision : 1.0 - initial release
// ============================================================================
package bram_pipe_pkg;

  localparam int c_MAX_READ_LATENCY = 8;

  function automatic int BE_WIDTH(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int CNT_W(input int rsp_depth);
    return $clog2(rsp_depth + 1);
  endfunction

  // A depth of one still needs a one-bit pointer.
  function automatic int PTR_W(input int rsp_depth);
    return (rsp_depth > 1) ? $clog2(rsp_depth) : 1;
  endfunction

  function automatic bit lat_legal(input int lat);
    return (lat >= 1) && (lat <= c_MAX_READ_LATENCY);
  endfunction

  function automatic bit depth_legal(input int depth);
    return depth >= 1;
  endfunction

  function automatic bit width_legal(input int width);
    return (width >= 8) && ((width % 8) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_sp_lat.sv
`default_nettype none
// ============================================================================
// Module   : bram_sp_lat
// Function : Inferred single-port byte-write RAM followed by READ_LATENCY output registers
// Revision : 1.0 - initial release
// ============================================================================
module bram_sp_lat
  import bram_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 3
) (
  input  logic                            clk_a,
  input  logic                            en,
  input  logic                            we,
  input  logic [BE_WIDTH(DATA_WIDTH)-1:0] be,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]           din,
  output logic [DATA_WIDTH-1:0]           dout
);

  localparam int c_BE_W = BE_WIDTH(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem  [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_pipe [READ_LATENCY];

  // Array read register; a write cycle leaves it untouched.
  always_ff @(posedge clk_a) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < c_BE_W; i++) begin
          if (be[i]) r_mem[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end else begin
        r_rd <= r_mem[addr];
      end
    end
  end

  always_ff @(posedge clk_a) begin
    r_pipe[0] <= r_rd;
    for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
  end

  assign dout = r_pipe[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/bram_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_pipe_ctrl
// Function : Pipelined single-port BRAM controller with credit-limited in-order read responses
// Revision : 1.0 - initial release
// ============================================================================
module bram_pipe_ctrl
  import bram_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 3,
  parameter int RSP_DEPTH    = 8
) (
  input  logic                            clk_a,
  input  logic                            arstz_aq,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_we,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  input  logic [BE_WIDTH(DATA_WIDTH)-1:0] req_be,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [CNT_W(RSP_DEPTH)-1:0]     outstanding,
  output logic                            busy
);

  localparam int c_CNT_W = CNT_W(RSP_DEPTH);
  localparam int c_PTR_W = PTR_W(RSP_DEPTH);
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(RSP_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(RSP_DEPTH - 1);

  if (!lat_legal(READ_LATENCY)) begin : g_chk_lat
    $error("bram_pipe_ctrl: READ_LATENCY must be within 1..8");
  end
  if (!depth_legal(RSP_DEPTH)) begin : g_chk_depth
    $error("bram_pipe_ctrl: RSP_DEPTH must be at least 1");
  end
  if (!width_legal(DATA_WIDTH)) begin : g_chk_width
    $error("bram_pipe_ctrl: DATA_WIDTH must be a multiple of 8");
  end

  logic                    w_accept;
  logic                    w_rd_accept;
  logic                    w_push;
  logic                    w_pop;
  logic [DATA_WIDTH-1:0]   w_ram_dout;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_CNT_W-1:0]      r_fcnt;
  logic [READ_LATENCY-1:0] r_tag;
  logic                    r_tag_exit;
  logic [c_PTR_W-1:0]      r_wptr;
  logic [c_PTR_W-1:0]      r_rptr;
  logic [DATA_WIDTH-1:0]   r_fifo [RSP_DEPTH];

  function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] ptr);
    return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  assign req_ready   = (r_cnt < c_DEPTH);
  assign w_accept    = req_valid & req_ready;
  assign w_rd_accept = w_accept & ~req_we;
  assign rsp_valid   = (r_fcnt != '0);
  assign w_pop       = rsp_valid & rsp_ready;
  assign w_push      = r_tag_exit;
  assign rsp_data    = rsp_valid ? r_fifo[r_rptr] : '0;
  assign outstanding = r_cnt;
  assign busy        = (r_cnt != '0);

  bram_sp_lat #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_ram (
    .clk_a (clk_a),
    .en    (w_accept),
    .we    (req_we),
    .be    (req_be),
    .addr  (req_addr),
    .din   (req_wdata),
    .dout  (w_ram_dout)
  );

  // The extra exit stage lines the tag up with the last RAM output register.
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      r_cnt      <= '0;
      r_fcnt     <= '0;
      r_tag      <= '0;
      r_tag_exit <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_cnt      <= r_cnt + c_CNT_W'(w_rd_accept) - c_CNT_W'(w_pop);
      r_fcnt     <= r_fcnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      r_tag      <= (r_tag << 1) | READ_LATENCY'(w_rd_accept);
      r_tag_exit <= r_tag[READ_LATENCY-1];
      if (w_push) r_wptr <= f_next_ptr(r_wptr);
      if (w_pop)  r_rptr <= f_next_ptr(r_rptr);
    end
  end

  always_ff @(posedge clk_a) begin
    if (w_push) r_fifo[r_wptr] <= w_ram_dout;
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_pipe_ctrl
// Function : Scoreboard bench for bram_pipe_ctrl with directed and random traffic
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_pipe_ctrl;

  localparam int c_AW = 15;
  localparam int c_DW = 32;
  localparam int c_L  = 3;
  localparam int c_D  = 8;

  logic            clk_a;
  logic            arstz_aq;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [c_AW-1:0] req_addr;
  logic [c_DW-1:0] req_wdata;
  logic [3:0]      req_be;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [c_DW-1:0] rsp_data;
  logic [3:0]      outstanding;
  logic            busy;

  bram_pipe_ctrl #(
    .ADDR_WIDTH   (c_AW),
    .DATA_WIDTH   (c_DW),
    .READ_LATENCY (c_L),
    .RSP_DEPTH    (c_D)
  ) dut (
    .clk_a       (clk_a),
    .arstz_aq    (arstz_aq),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .outstanding (outstanding),
    .busy        (busy)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mmem [64];
  int          m_cnt;
  int          cyc;
  int          n_chk;
  int          n_fail;

  initial begin
    clk_a = 1'b0;
    forever #5 clk_a = ~clk_a;
  end

  initial cyc = 0;
  always @(posedge clk_a) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: a read seen at cycle c is accepted at the next edge and its data
  // becomes visible READ_LATENCY+1 edges after that, popped strictly in order.
  always @(negedge clk_a) begin : scoreboard
    bit exp_ready;
    bit exp_v;
    if (!arstz_aq) begin
      q.delete();
      m_cnt = 0;
    end else begin
      exp_ready = (m_cnt < c_D);
      chk("req_ready", req_ready, exp_ready);
      chk("outstanding", outstanding, m_cnt);
      chk("busy", busy, m_cnt != 0);
      exp_v = (q.size() != 0) && (q[0].due <= cyc);
      chk("rsp_valid", rsp_valid, exp_v);
      chk("fifo_no_overflow",
          dut.w_push && !dut.w_pop && (dut.r_fcnt == 4'(c_D)), 1'b0);
      if (rsp_valid && q.size() != 0) begin
        chk("rsp_data", rsp_data, q[0].data);
        if (rsp_ready) begin
          void'(q.pop_front());
          m_cnt--;
        end
      end
      if (req_valid && exp_ready) begin
        if (req_we) begin
          for (int b = 0; b < 4; b++)
            if (req_be[b]) mmem[req_addr[5:0]][8*b +: 8] = req_wdata[8*b +: 8];
        end else begin
          q.push_back('{data: mmem[req_addr[5:0]], due: cyc + c_L + 2});
          m_cnt++;
        end
      end
    end
  end

  task automatic issue(input bit we, input int addr, input logic [31:0] d, input logic [3:0] be);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = c_AW'(addr);
    req_wdata = d;
    req_be    = be;
    while (!acc && t < 200) begin
      @(negedge clk_a);
      acc = req_ready;
      @(posedge clk_a);
      #1;
      t++;
    end
    if (!acc) chk("issue_timeout", t, 0);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk_a);
      #1;
      t++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_data"}, rsp_data, 32'h0);
    chk({tag, "_outstanding"}, outstanding, 4'h0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic apply_reset(input string tag);
    @(posedge clk_a);
    #3 arstz_aq = 1'b0;
    #1 check_reset_outputs(tag);
    @(posedge clk_a);
    #1 arstz_aq = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_fail = 0; m_cnt = 0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1; arstz_aq = 1'b1;

    // Asynchronous reset asserted between edges
    #3 arstz_aq = 1'b0;
    #1 check_reset_outputs("t1");
    repeat (2) @(posedge clk_a);
    #1 arstz_aq = 1'b1;

    for (int a = 0; a < 64; a++) issue(1'b1, a, 32'(a * 3), 4'hF);

    issue(1'b1, 16, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 16, 32'h0, 4'h0);
    wait_drain();

    issue(1'b1, 16, 32'h11223344, 4'b0101);
    issue(1'b0, 16, 32'h0, 4'h0);
    wait_drain();

    issue(1'b1, 17, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 17, 32'h0, 4'h0);
    wait_drain();

    for (int a = 0; a < 16; a++) issue(1'b0, a, 32'h0, 4'h0);
    wait_drain();

    // Credit exhaustion with a stalled consumer
    rsp_ready = 1'b0;
    fork
      for (int i = 0; i < 12; i++) issue(1'b0, 20 + i, 32'h0, 4'h0);
    join_none
    repeat (20) @(posedge clk_a);
    @(negedge clk_a);
    chk("t5_outstanding", outstanding, 4'd8);
    chk("t5_req_ready", req_ready, 1'b0);
    @(posedge clk_a);
    #1 rsp_ready = 1'b1;
    wait fork;
    wait_drain();

    // Reset with reads in flight
    for (int i = 0; i < 3; i++) issue(1'b0, 40 + i, 32'h0, 4'h0);
    apply_reset("t6");
    repeat (10) @(posedge clk_a);
    @(negedge clk_a);
    chk("t6_outstanding", outstanding, 4'd0);
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk_a);
    #1;
    issue(1'b0, 5, 32'h0, 4'h0);
    wait_drain();

    repeat (400) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 2) == 0);
      req_addr  = c_AW'($urandom_range(0, 63));
      req_wdata = $urandom;
      req_be    = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk_a);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_drain();
    chk("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
